mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single backing data memory between the instruction-fetch requester (port I, l1 instruction side) and the data requester (port D, l1_cache refill/writeback).
- Fair round-robin grant, one outstanding memory transaction at a time, registered memory-side handshake, per-transaction error on out-of-range address or memory timeout.
- Sits between the CPU-side caches and the data memory, inside the CPU top level.

---
 rtl/mem_pkg.sv | 16 +
 rtl/rr_arb2.sv | 11 +
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and encodings for the two-port memory arbiter.
package mem_pkg;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 512;
  localparam int TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port that was not served last.
module rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_vld,
  output logic o_id
);
  assign o_vld = i_req0 | i_req1;
  assign o_id  = (i_req0 & i_req1) ? ~i_last : i_req1;
endmodule

// File: rtl/mem_arbiter.sv
// Shares one data memory between the instruction-fetch port (I) and the data port (D),
// one transaction at a time, with range check and ready timeout.
module mem_arbiter #(
  parameter int ADDR_W  = mem_pkg::ADDR_W,
  parameter int DATA_W  = mem_pkg::DATA_W,
  parameter int DEPTH   = mem_pkg::DEPTH,
  parameter int TIMEOUT = mem_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_ack,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              grant_id
);
  import mem_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      TO_L    = 8'(TIMEOUT);

  state_t              r_state, w_next;
  logic [7:0]          r_cnt;
  logic                r_last, r_gid;
  logic                r_mem_req, r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_i_ack, r_i_err, r_d_ack, r_d_err;
  logic [DATA_W-1:0]   r_i_rdata, r_d_rdata;

  logic                w_gnt_vld, w_gnt_id;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_oor, w_to_hit;
  logic                w_fin, w_fin_err, w_fin_port, w_cap;

  rr_arb2 u_rr (
    .i_req0 (i_req),
    .i_req1 (d_req),
    .i_last (r_last),
    .o_vld  (w_gnt_vld),
    .o_id   (w_gnt_id)
  );

  assign w_sel_we    = (w_gnt_id == PORT_D) ? d_we    : i_we;
  assign w_sel_addr  = (w_gnt_id == PORT_D) ? d_addr  : i_addr;
  assign w_sel_wdata = (w_gnt_id == PORT_D) ? d_wdata : i_wdata;
  assign w_oor       = {1'b0, w_sel_addr} >= DEPTH_L;
  assign w_to_hit    = (r_cnt == TO_L);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state plus the completion decision (which port finishes, and with what status).
  always_comb begin
    w_next     = r_state;
    w_fin      = 1'b0;
    w_fin_err  = 1'b0;
    w_fin_port = r_gid;
    w_cap      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          w_next = w_oor ? ST_RESP : ST_GRANT;
          if (w_oor) begin
            w_fin      = 1'b1;
            w_fin_err  = 1'b1;
            w_fin_port = w_gnt_id;
          end
        end
      end
      ST_GRANT: begin
        if (mem_ready) begin
          w_next = ST_RESP;
          w_fin  = 1'b1;
          w_cap  = ~r_mem_we;
        end else if (w_to_hit) begin
          w_next    = ST_RESP;
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_last      <= PORT_D;
      r_gid       <= PORT_I;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_ack     <= 1'b0;
      r_i_err     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_d_err     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      // Ack/err are registered so they appear in the RESP cycle.
      r_i_ack <= w_fin & (w_fin_port == PORT_I);
      r_i_err <= w_fin & w_fin_err & (w_fin_port == PORT_I);
      r_d_ack <= w_fin & (w_fin_port == PORT_D);
      r_d_err <= w_fin & w_fin_err & (w_fin_port == PORT_D);
      if (w_cap && (r_gid == PORT_I)) r_i_rdata <= mem_rdata;
      if (w_cap && (r_gid == PORT_D)) r_d_rdata <= mem_rdata;
      if (r_state == ST_IDLE && w_gnt_vld) begin
        r_gid       <= w_gnt_id;
        r_mem_we    <= w_sel_we;
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
        r_cnt       <= '0;
        r_mem_req   <= ~w_oor;
      end else if (r_state == ST_GRANT) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_fin) r_mem_req <= 1'b0;
      end
      if (r_state == ST_RESP) r_last <= r_gid;
    end
  end

  assign i_ack     = r_i_ack;
  assign i_err     = r_i_err;
  assign i_rdata   = r_i_rdata;
  assign d_ack     = r_d_ack;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != ST_IDLE);
  assign grant_id  = r_gid;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory of programmable latency.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_we, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic          i_ack, i_err, d_ack, d_err;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, grant_id;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] memarr [0:(1<<AW)-1];
  int  lat  = 0;
  bit  hang = 1'b0;
  int  rcnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(512), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .grant_id(grant_id)
  );

  // Memory answers after lat extra cycles of mem_req; junk on rdata otherwise.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_rdata = 32'hBAD0_0000 | 32'(rcnt);
    if (mem_req) begin
      if (!hang && rcnt == lat) begin
        mem_ready = 1'b1;
        if (mem_we) memarr[mem_addr] = mem_wdata;
        else        mem_rdata = memarr[mem_addr];
      end
      rcnt++;
    end else begin
      rcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int maxc, output int ncyc, output int nreq,
                          output logic port, output logic err);
    bit got = 1'b0;
    ncyc = 0; nreq = 0; port = 1'b0; err = 1'b0;
    while (!got && ncyc < maxc) begin
      @(negedge clk);
      ncyc++;
      if (mem_req) nreq++;
      if (i_ack || d_ack) begin
        got  = 1'b1;
        port = d_ack;
        err  = d_ack ? d_err : i_err;
      end
    end
    if (!got) chk("ack_wait_expired", 64'(ncyc), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   ncyc, nreq, nack;
    logic port, err;
    logic exp_port;
    for (int k = 0; k < (1<<AW); k++) memarr[k] = '0;
    memarr[5]  = 32'hDEADBEEF;
    memarr[6]  = 32'h6666_6666;
    memarr[10] = 32'h1010_1010;
    memarr[20] = 32'h2020_2020;
    rst = 1'b1; i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",     64'(busy),     64'(0));
    chk("rst_mem_req",  64'(mem_req),  64'(0));
    chk("rst_acks",     64'({i_ack, d_ack, i_err, d_err}), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    chk("rst_rdata",    64'(i_rdata | d_rdata), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single read, zero-wait memory.
    lat = 0; i_req = 1; i_we = 0; i_addr = 10'd5;
    @(negedge clk);
    chk("rd_mem_req",  64'(mem_req),  64'(1));
    chk("rd_mem_addr", 64'(mem_addr), 64'(5));
    chk("rd_busy",     64'(busy),     64'(1));
    wait_ack(10, ncyc, nreq, port, err);
    chk("rd_latency",  64'(ncyc + 1), 64'(2));
    chk("rd_mem_cyc",  64'(nreq + 1), 64'(1));
    chk("rd_port",     64'(port),     64'(0));
    chk("rd_err",      64'(err),      64'(0));
    chk("rd_rdata",    64'(i_rdata),  64'(32'hDEADBEEF));
    chk("rd_no_dack",  64'(d_ack),    64'(0));
    i_req = 0;
    @(negedge clk);
    chk("rd_ack_pulse", 64'(i_ack),   64'(0));
    chk("rd_idle",      64'(busy),    64'(0));

    // Contention from reset: both held, memory ready on second GRANT cycle.
    rst = 1; lat = 1;
    i_req = 1; i_addr = 10'd10; d_req = 1; d_addr = 10'd20; d_we = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    nack = 0; exp_port = 1'b0;
    for (int c = 0; c < 40 && nack < 4; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        chk("ct_onehot", 64'(i_ack & d_ack), 64'(0));
        chk("ct_order",  64'(d_ack), 64'(exp_port));
        chk("ct_addr",   64'(mem_addr), exp_port ? 64'(20) : 64'(10));
        chk("ct_rdata",  64'(exp_port ? d_rdata : i_rdata),
                         exp_port ? 64'(32'h2020_2020) : 64'(32'h1010_1010));
        exp_port = ~exp_port;
        nack++;
        if (nack == 4) begin i_req = 0; d_req = 0; end
      end
    end
    chk("ct_acks", 64'(nack), 64'(4));
    repeat (2) @(negedge clk);

    // Write on port D to the top valid address.
    lat = 1; d_req = 1; d_we = 1; d_addr = 10'd511; d_wdata = 32'h12345678;
    @(negedge clk);
    chk("wr_mem_we",    64'(mem_we),    64'(1));
    chk("wr_mem_wdata", 64'(mem_wdata), 64'(32'h12345678));
    chk("wr_mem_addr",  64'(mem_addr),  64'(511));
    chk("wr_grant_id",  64'(grant_id),  64'(1));
    wait_ack(10, ncyc, nreq, port, err);
    chk("wr_mem_cyc",   64'(nreq + 1),  64'(2));
    chk("wr_port",      64'(port),      64'(1));
    chk("wr_err",       64'(err),       64'(0));
    chk("wr_rdata_keep", 64'(d_rdata),  64'(32'h2020_2020));
    chk("wr_mem_content", 64'(memarr[511]), 64'(32'h12345678));
    d_req = 0; d_we = 0;
    repeat (2) @(negedge clk);

    // Out-of-range address: no memory access, error ack.
    i_req = 1; i_addr = 10'd512;
    wait_ack(10, ncyc, nreq, port, err);
    chk("oor_latency", 64'(ncyc), 64'(1));
    chk("oor_mem_cyc", 64'(nreq), 64'(0));
    chk("oor_port",    64'(port), 64'(0));
    chk("oor_err",     64'(err),  64'(1));
    i_req = 0;
    @(negedge clk);
    chk("oor_err_clr", 64'(i_err), 64'(0));
    @(negedge clk);

    // Timeout on D with I pending behind it; last served was I so D wins the tie.
    hang = 1; d_req = 1; d_addr = 10'd30; i_req = 1; i_addr = 10'd5;
    wait_ack(40, ncyc, nreq, port, err);
    chk("to_latency", 64'(ncyc), 64'(TO + 2));
    chk("to_mem_cyc", 64'(nreq), 64'(TO + 1));
    chk("to_port",    64'(port), 64'(1));
    chk("to_err",     64'(err),  64'(1));
    chk("to_no_iack", 64'(i_ack), 64'(0));
    d_req = 0; hang = 0; lat = 0;
    wait_ack(10, ncyc, nreq, port, err);
    chk("to_next_port",  64'(port),    64'(0));
    chk("to_next_err",   64'(err),     64'(0));
    chk("to_next_rdata", 64'(i_rdata), 64'(32'hDEADBEEF));
    chk("to_next_lat",   64'(ncyc),    64'(3));
    i_req = 0;
    repeat (2) @(negedge clk);

    // Reset while a transaction is waiting on memory.
    hang = 1; i_req = 1; i_addr = 10'd6;
    @(negedge clk);
    chk("rg_mem_req", 64'(mem_req), 64'(1));
    rst = 1;
    @(negedge clk);
    chk("rg_mem_req_drop", 64'(mem_req), 64'(0));
    chk("rg_busy",         64'(busy),    64'(0));
    chk("rg_no_ack",       64'(i_ack | d_ack), 64'(0));
    rst = 0; hang = 0; lat = 0;
    wait_ack(10, ncyc, nreq, port, err);
    chk("rg_port",  64'(port),    64'(0));
    chk("rg_err",   64'(err),     64'(0));
    chk("rg_rdata", 64'(i_rdata), 64'(32'h6666_6666));
    i_req = 0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
